seven_seg_scan_reader: RTL and testbench

- Receiving end of the multiplexed 7-segment display interface: watches a scanned display bus (per-digit enable strobes plus shared segment lines) and reconstructs the hex value shown on each digit.
- Used for loopback self-test of the display path and for reading external scanned displays.
- Synchronises the inputs, requires a stable pattern for a programmable number of cycles, reverse-maps the pattern to a nibble, and stores per-digit results.

---
 rtl/seg7_pkg.sv | 28 ++
 rtl/seg7_pattern_to_hex.sv | 22 ++
 rtl/seven_seg_scan_reader.sv | 190 +++++++++++++++++++
 tb/tb_seven_seg_scan_reader.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: glyph patterns (a..g,dp with dp=0), reader FSM states,
// digit-count upper bound and a one-hot to index helper.
package seg7_pkg;

  localparam int SEG7_MAX_DIGITS = 8;

  // Index k holds the pattern for hex value k; SEG[7]=a ... SEG[1]=g, SEG[0]=dp
  localparam logic [15:0][7:0] SEG7_GLYPHS = {
    8'h8E, 8'h9E, 8'h7A, 8'h9C, 8'h3E, 8'hEE, 8'hF6, 8'hFE,
    8'hE0, 8'hBE, 8'hB6, 8'h66, 8'hF2, 8'hDA, 8'h60, 8'hFC
  };

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_HOLD  = 2'd2
  } seg7_state_e;

  function automatic logic [2:0] seg7_onehot_idx(input logic [SEG7_MAX_DIGITS-1:0] onehot);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < SEG7_MAX_DIGITS; i++) begin
      if (onehot[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/seg7_pattern_to_hex.sv
// Combinational reverse map of a 7-bit segment pattern (a..g) to a hex nibble.
// Unknown patterns, including blank, give nibble 0 with o_ok low.
module seg7_pattern_to_hex
  import seg7_pkg::*;
(
  input  logic [6:0] i_pattern,
  output logic       o_ok,
  output logic [3:0] o_nibble
);

  always_comb begin
    o_ok     = 1'b0;
    o_nibble = 4'h0;
    for (int k = 0; k < 16; k++) begin
      if (i_pattern == SEG7_GLYPHS[k][7:1]) begin
        o_ok     = 1'b1;
        o_nibble = 4'(k);
      end
    end
  end

endmodule

// File: rtl/seven_seg_scan_reader.sv
// Reads a scanned 7-segment bus back into per-digit hex values after a stability window.
// Optional SEG_READER_ERR_CNT_EN adds o_err_cnt (bad glyph commits + multi-hot aborts).
//
// state    | meaning
// ST_IDLE  | no valid one-hot sample being tracked
// ST_TRACK | counting consecutive identical samples against r_ref
// ST_HOLD  | r_ref committed; wait for a change or invalid sample
module seven_seg_scan_reader
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [7:0]              i_seg,
  input  logic [NUM_DIGITS-1:0]   i_an,
  output logic [4*NUM_DIGITS-1:0] o_digits,
  output logic [NUM_DIGITS-1:0]   o_dp,
  output logic [NUM_DIGITS-1:0]   o_digit_ok,
  output logic                    o_update,
  output logic [2:0]              o_upd_idx,
  output logic                    o_frame_done
`ifdef SEG_READER_ERR_CNT_EN
  ,
  output logic [7:0]              o_err_cnt
`endif
);

  localparam int CNT_W  = (STABLE_CYCLES < 2) ? 1 : $clog2(STABLE_CYCLES + 1);
  localparam int SAMP_W = NUM_DIGITS + 8;

  logic [7:0]              r_seg_m, r_seg_s;
  logic [NUM_DIGITS-1:0]   r_an_m, r_an_s;
  seg7_state_e             r_state, w_state_nxt;
  logic [SAMP_W-1:0]       r_ref, w_ref_nxt;
  logic [CNT_W-1:0]        r_cnt, w_cnt_nxt;
  logic [4*NUM_DIGITS-1:0] r_digits;
  logic [NUM_DIGITS-1:0]   r_dp, r_digit_ok, r_seen;
  logic                    r_update, r_frame_done;
  logic [2:0]              r_upd_idx;

  logic [SAMP_W-1:0]       w_sample;
  logic                    w_valid, w_commit, w_glyph_ok;
  logic [3:0]              w_nibble;
  logic [NUM_DIGITS-1:0]   w_seen_nxt;

  assign w_sample   = {r_an_s, r_seg_s};
  assign w_valid    = $onehot(r_an_s);
  assign w_seen_nxt = r_seen | r_an_s;

  seg7_pattern_to_hex u_p2h (
    .i_pattern (r_seg_s[7:1]),
    .o_ok      (w_glyph_ok),
    .o_nibble  (w_nibble)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_seg_m <= '0;
      r_seg_s <= '0;
      r_an_m  <= '0;
      r_an_s  <= '0;
      r_state <= ST_IDLE;
      r_ref   <= '0;
      r_cnt   <= '0;
    end else begin
      r_seg_m <= i_seg;
      r_seg_s <= r_seg_m;
      r_an_m  <= i_an;
      r_an_s  <= r_an_m;
      r_state <= w_state_nxt;
      r_ref   <= w_ref_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // With a one-cycle window every fresh valid sample commits straight into HOLD
  always_comb begin
    w_state_nxt = r_state;
    w_ref_nxt   = r_ref;
    w_cnt_nxt   = r_cnt;
    w_commit    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_valid) begin
          w_ref_nxt = w_sample;
          w_cnt_nxt = CNT_W'(1);
          if (STABLE_CYCLES == 1) begin
            w_commit    = 1'b1;
            w_state_nxt = ST_HOLD;
          end else begin
            w_state_nxt = ST_TRACK;
          end
        end
      end
      ST_TRACK: begin
        if (!w_valid) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else if (w_sample == r_ref) begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(STABLE_CYCLES - 1)) begin
            w_commit    = 1'b1;
            w_state_nxt = ST_HOLD;
          end
        end else begin
          w_ref_nxt = w_sample;
          w_cnt_nxt = CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (!w_valid) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else if (w_sample != r_ref) begin
          w_ref_nxt = w_sample;
          w_cnt_nxt = CNT_W'(1);
          if (STABLE_CYCLES == 1) begin
            w_commit = 1'b1;
          end else begin
            w_state_nxt = ST_TRACK;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_digits     <= '0;
      r_dp         <= '0;
      r_digit_ok   <= '0;
      r_seen       <= '0;
      r_update     <= 1'b0;
      r_upd_idx    <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_update     <= 1'b0;
      r_frame_done <= 1'b0;
      if (w_commit) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (r_an_s[i]) begin
            r_digits[4*i +: 4] <= w_nibble;
            r_dp[i]            <= r_seg_s[0];
            r_digit_ok[i]      <= w_glyph_ok;
          end
        end
        r_update  <= 1'b1;
        r_upd_idx <= seg7_onehot_idx(SEG7_MAX_DIGITS'(r_an_s));
        if (&w_seen_nxt) begin
          r_frame_done <= 1'b1;
          r_seen       <= '0;
        end else begin
          r_seen <= w_seen_nxt;
        end
      end
    end
  end

  assign o_digits     = r_digits;
  assign o_dp         = r_dp;
  assign o_digit_ok   = r_digit_ok;
  assign o_update     = r_update;
  assign o_upd_idx    = r_upd_idx;
  assign o_frame_done = r_frame_done;

`ifdef SEG_READER_ERR_CNT_EN
  logic       w_abort_multi;
  logic [7:0] r_err_cnt;

  // Only a window in progress counts as aborted; HOLD->IDLE is a normal end of scan
  assign w_abort_multi = (r_state == ST_TRACK) && (r_an_s != '0) && !w_valid;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_err_cnt <= '0;
    end else if (((w_commit && !w_glyph_ok) || w_abort_multi) && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign o_err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_seven_seg_scan_reader.sv
// Scoreboard bench for seven_seg_scan_reader: expected commits are queued as stimulus is
// driven and matched against UPDATE pulses, including commit cycle and FRAME_DONE.
module tb_seven_seg_scan_reader;

  localparam int NUM_DIGITS = 4;
  localparam int STABLE     = 16;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [7:0]              seg;
  logic [NUM_DIGITS-1:0]   an;
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   dp, digit_ok;
  logic                    update, frame_done;
  logic [2:0]              upd_idx;
`ifdef SEG_READER_ERR_CNT_EN
  logic [7:0]              err_cnt;
`endif

  seven_seg_scan_reader #(.NUM_DIGITS(NUM_DIGITS), .STABLE_CYCLES(STABLE)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_seg        (seg),
    .i_an         (an),
    .o_digits     (digits),
    .o_dp         (dp),
    .o_digit_ok   (digit_ok),
    .o_update     (update),
    .o_upd_idx    (upd_idx),
    .o_frame_done (frame_done)
`ifdef SEG_READER_ERR_CNT_EN
    ,
    .o_err_cnt    (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int       idx;
    logic [3:0] nib;
    logic     dp;
    logic     ok;
    logic     fd;
    int       exp_cyc;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] model_glyph [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                                   8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};
  logic [NUM_DIGITS-1:0] model_seen = '0;
  int   model_err  = 0;
  bit   prev_valid = 1'b0;
  int   prev_n     = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push_commit(input logic [NUM_DIGITS-1:0] a, input logic [7:0] s, input int exp_cyc);
    exp_t e;
    logic [7:0] g;
    e.ok  = 1'b0;
    e.nib = 4'h0;
    e.idx = 0;
    for (int k = 0; k < 16; k++) begin
      g = model_glyph[k];
      if (s[7:1] == g[7:1]) begin
        e.ok  = 1'b1;
        e.nib = 4'(k);
      end
    end
    for (int i = 0; i < NUM_DIGITS; i++) if (a[i]) e.idx = i;
    e.dp = s[0];
    model_seen = model_seen | a;
    e.fd = &model_seen;
    if (e.fd) model_seen = '0;
    if (!e.ok && model_err < 255) model_err++;
    e.exp_cyc = exp_cyc;
    sb.push_back(e);
  endtask

  task automatic hold(input logic [NUM_DIGITS-1:0] a, input logic [7:0] s, input int n);
    an  = a;
    seg = s;
    if ($onehot(a) && n >= STABLE) push_commit(a, s, cyc + STABLE + 2);
    if (a != '0 && !$onehot(a) && prev_valid && prev_n < STABLE && model_err < 255) model_err++;
    prev_valid = $onehot(a);
    prev_n     = n;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_err(input string tag);
`ifdef SEG_READER_ERR_CNT_EN
    check(tag, 32'(err_cnt), 32'(model_err));
`endif
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst) begin
      if (sb.size() > 0 && cyc > sb[0].exp_cyc) begin
        e = sb.pop_front();
        check("missed_update_cycle", 32'(cyc), 32'(e.exp_cyc));
      end
      if (update) begin
        if (sb.size() == 0) begin
          check("unexpected_update", 32'(update), 32'd0);
        end else begin
          e = sb.pop_front();
          check("upd_idx",    32'(upd_idx),            32'(e.idx));
          check("upd_nibble", 32'(digits[e.idx*4 +: 4]), 32'(e.nib));
          check("upd_dp",     32'(dp[e.idx]),          32'(e.dp));
          check("upd_ok",     32'(digit_ok[e.idx]),    32'(e.ok));
          check("frame_done", 32'(frame_done),         32'(e.fd));
          check("upd_cycle",  32'(cyc),                32'(e.exp_cyc));
        end
      end else if (frame_done) begin
        check("frame_done_alone", 32'(frame_done), 32'd0);
      end
    end
  end

  int t0, r_edge;

  initial begin
    rst = 1'b1;
    an  = '0;
    seg = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_digits", 32'(digits), 32'd0);
    check("rst_dp", 32'(dp), 32'd0);
    check("rst_ok", 32'(digit_ok), 32'd0);
    check("rst_update", 32'(update), 32'd0);
    check("rst_idx", 32'(upd_idx), 32'd0);
    check("rst_fd", 32'(frame_done), 32'd0);
    check_err("rst_err");
    rst = 1'b0;
    hold('0, 8'h00, 3);

    // single digit, latency
    hold(4'b0001, 8'hDA, 20);
    check("d0_value", 32'(digits[3:0]), 32'h2);

    // full scan with dp on digit 3
    hold(4'b0001, 8'hFC, 32);
    hold(4'b0010, 8'h60, 32);
    hold(4'b0100, 8'hF6, 32);
    hold(4'b1000, 8'h8F, 32);
    check("scan_digits", 32'(digits), 32'hF910);
    check("scan_dp", 32'(dp), 32'b1000);
    check("scan_ok", 32'(digit_ok), 32'b1111);

    // change mid-window restarts the window
    hold(4'b0010, 8'hFE, 10);
    hold(4'b0010, 8'h3E, 20);
    check("restart_digit1", 32'(digits[7:4]), 32'hB);
    hold('0, 8'h00, 3);

    // multi-hot from idle
    hold(4'b0110, 8'h60, 40);
    check_err("multi_from_idle_err");
    hold('0, 8'h00, 3);

    // illegal glyphs
    hold(4'b0100, 8'h02, 20);
    check("bad_glyph_ok", 32'(digit_ok[2]), 32'd0);
    check_err("err_after_first_bad");
    hold(4'b1000, 8'h01, 20);
    check("blank_dp", 32'(dp[3]), 32'd1);
    check_err("err_after_blank");

    // multi-hot abort of a window in progress
    hold(4'b0001, 8'h9C, 5);
    hold(4'b1001, 8'h9C, 5);
    check_err("err_after_abort");
    hold('0, 8'h00, 3);

    for (int r = 0; r < 300; r++) begin
      hold('0, 8'h00, 2);
      hold(4'b0100, 8'h02, 16);
    end
    hold('0, 8'h00, 5);
    check_err("err_saturated");

    // reset at cnt=10 aborts the window; it restarts after release
    an  = 4'b0001;
    seg = 8'hB6;
    t0  = cyc;
    repeat (12) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_digits", 32'(digits), 32'd0);
    check("mid_rst_dp", 32'(dp), 32'd0);
    check("mid_rst_ok", 32'(digit_ok), 32'd0);
    check("mid_rst_update", 32'(update), 32'd0);
    check("mid_rst_sb_empty", 32'(sb.size()), 32'd0);
    model_seen = '0;
    model_err  = 0;
    rst    = 1'b0;
    r_edge = cyc;
    push_commit(4'b0001, 8'hB6, r_edge + STABLE + 2);
    repeat (20) @(posedge clk);
    #1;
    prev_valid = 1'b1;
    prev_n     = 20;
    check("post_rst_digit0", 32'(digits[3:0]), 32'h5);
    check_err("post_rst_err");
    hold('0, 8'h00, 30);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
